// File: rtl/fp_addsub_if.sv
// Start/done handshake and operand/result bundle for the sequential FP adder.
interface fp_addsub_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
);
  localparam int unsigned W = 1 + EXP_W + MAN_W;

  logic         start;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         flag_invalid;
  logic         flag_ovf;
  logic         flag_unf;
  logic         flag_inexact;

  modport master (
    output start, op_sub, a, b,
    input  busy, done, result, flag_invalid, flag_ovf, flag_unf, flag_inexact
  );

  modport slave (
    input  start, op_sub, a, b,
    output busy, done, result, flag_invalid, flag_ovf, flag_unf, flag_inexact
  );
endinterface

// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754 adder/subtractor, round-to-nearest-even, subnormals flushed to zero.
// One state per cycle: IDLE -> ALIGN -> ADD -> NORM -> ROUND; done pulses on leaving ROUND.
module fp_addsub_seq #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input logic        clk,
  input logic        reset_n,
  fp_addsub_if.slave bus
);

  localparam int unsigned W     = 1 + EXP_W + MAN_W;
  localparam int unsigned SIG_W = MAN_W + 1;
  localparam int unsigned SW    = MAN_W + 4;  // significand plus guard, round, sticky
  localparam int unsigned EW    = EXP_W + 2;  // signed exponent with headroom both ways

  localparam logic [EXP_W-1:0]        ExpOnes = '1;
  localparam logic [EXP_W-1:0]        ShMax   = EXP_W'(MAN_W + 3);
  localparam logic signed [EW-1:0]    ExpMax  = {2'b00, {EXP_W{1'b1}}};
  localparam logic [W-1:0]            QNaN    = {1'b0, ExpOnes, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StAlign, StAdd, StNorm, StRound} state_e;

  state_e                state_q, state_d;
  logic [W-1:0]          a_q, b_q;
  logic                  op_q;
  logic [SW-1:0]         big_q, small_q;
  logic                  sign_q, sub_q, zsign_q;
  logic signed [EW-1:0]  exp_q, nexp_q;
  logic [SW:0]           sum_q;
  logic [SW-1:0]         norm_q;
  logic [W-1:0]          result_q;
  logic                  done_q, inv_q, ovf_q, unf_q, inx_q;

  // Unpack the held operands; B carries the operation in its effective sign.
  logic               sa, sb, za, zb, a_big;
  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W-1:0]   fa, fb;
  logic [SIG_W-1:0]   sig_a, sig_b;
  logic [W-2:0]       mag_a, mag_b;
  logic               nan_a, nan_b, inf_a, inf_b;

  assign sa    = a_q[W-1];
  assign sb    = b_q[W-1] ^ op_q;
  assign ea    = a_q[W-2:MAN_W];
  assign eb    = b_q[W-2:MAN_W];
  assign fa    = a_q[MAN_W-1:0];
  assign fb    = b_q[MAN_W-1:0];
  assign za    = (ea == '0);
  assign zb    = (eb == '0);
  assign sig_a = za ? '0 : {1'b1, fa};
  assign sig_b = zb ? '0 : {1'b1, fb};
  assign mag_a = za ? '0 : a_q[W-2:0];
  assign mag_b = zb ? '0 : b_q[W-2:0];
  assign a_big = (mag_a >= mag_b);
  assign nan_a = (ea == ExpOnes) && (fa != '0);
  assign nan_b = (eb == ExpOnes) && (fb != '0);
  assign inf_a = (ea == ExpOnes) && (fa == '0);
  assign inf_b = (eb == ExpOnes) && (fb == '0);

  // ALIGN
  logic [EXP_W-1:0]     e_big, e_sml, e_diff, sh_amt;
  logic [SIG_W-1:0]     s_big, s_sml;
  logic [2*SW-1:0]      sh_w;
  logic [SW-1:0]        big_d, small_d;
  logic                 sign_d;
  logic signed [EW-1:0] exp_d;

  always_comb begin
    if (a_big) begin
      e_big = ea;
      e_sml = eb;
      s_big = sig_a;
      s_sml = sig_b;
    end else begin
      e_big = eb;
      e_sml = ea;
      s_big = sig_b;
      s_sml = sig_a;
    end
    e_diff  = e_big - e_sml;
    sh_amt  = (e_diff > ShMax) ? ShMax : e_diff;
    // Lower half of the wide shift collects everything pushed past the round bit.
    sh_w    = {s_sml, 3'b000, {SW{1'b0}}} >> sh_amt;
    small_d = {sh_w[2*SW-1:SW+1], sh_w[SW] | (|sh_w[SW-1:0])};
    big_d   = {s_big, 3'b000};
    sign_d  = a_big ? sa : sb;
    exp_d   = {2'b00, e_big};
  end

  // ADD: operands are ordered by magnitude, so the difference never goes negative.
  logic [SW:0] sum_d;
  assign sum_d = sub_q ? ({1'b0, big_q} - {1'b0, small_q}) : ({1'b0, big_q} + {1'b0, small_q});

  // NORM
  int                   lz;
  logic                 found;
  logic [SW-1:0]        norm_d;
  logic signed [EW-1:0] nexp_d;

  always_comb begin
    lz    = 0;
    found = 1'b0;
    for (int i = SW - 1; i >= 0; i--) begin
      if (!found) begin
        if (sum_q[i]) found = 1'b1;
        else          lz    = lz + 1;
      end
    end
    if (sum_q[SW]) begin
      norm_d = {sum_q[SW:2], sum_q[1] | sum_q[0]};
      nexp_d = exp_q + EW'(1);
    end else begin
      norm_d = sum_q[SW-1:0] << lz;
      nexp_d = exp_q - EW'(lz);
    end
  end

  // ROUND plus special-case override
  logic                 g, r, s, rup;
  logic [SIG_W:0]       mant_r;
  logic signed [EW-1:0] e_rnd;
  logic [W-1:0]         res_d;
  logic                 inv_d, ovf_d, unf_d, inx_d;
  logic                 unused_hidden;

  assign unused_hidden = mant_r[MAN_W];

  always_comb begin
    g      = norm_q[2];
    r      = norm_q[1];
    s      = norm_q[0];
    rup    = g & (r | s | norm_q[3]);
    mant_r = {1'b0, norm_q[SW-1:3]} + {{SIG_W{1'b0}}, rup};
    e_rnd  = nexp_q + {{(EW-1){1'b0}}, mant_r[SIG_W]};
    inv_d  = 1'b0;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    inx_d  = g | r | s;
    if (norm_q == '0) begin
      res_d = {zsign_q, {(W-1){1'b0}}};
      inx_d = 1'b0;
    end else if (e_rnd >= ExpMax) begin
      res_d = {sign_q, ExpOnes, {MAN_W{1'b0}}};
      ovf_d = 1'b1;
      inx_d = 1'b1;
    end else if (e_rnd[EW-1] || (e_rnd == '0)) begin
      res_d = {sign_q, {(W-1){1'b0}}};
      unf_d = 1'b1;
      inx_d = 1'b1;
    end else begin
      // On a rounding carry the low fraction bits are already zero.
      res_d = {sign_q, e_rnd[EXP_W-1:0], mant_r[MAN_W-1:0]};
    end

    if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) begin
      res_d = QNaN;
      inv_d = 1'b1;
      ovf_d = 1'b0;
      unf_d = 1'b0;
      inx_d = 1'b0;
    end else if (inf_a || inf_b) begin
      res_d = {inf_a ? sa : sb, ExpOnes, {MAN_W{1'b0}}};
      ovf_d = 1'b0;
      unf_d = 1'b0;
      inx_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StAlign;
      StAlign: state_d = StAdd;
      StAdd:   state_d = StNorm;
      StNorm:  state_d = StRound;
      StRound: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 1'b0;
      big_q    <= '0;
      small_q  <= '0;
      sign_q   <= 1'b0;
      sub_q    <= 1'b0;
      zsign_q  <= 1'b0;
      exp_q    <= '0;
      sum_q    <= '0;
      norm_q   <= '0;
      nexp_q   <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      inv_q    <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inx_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (state_q == StIdle && bus.start) begin
        a_q  <= bus.a;
        b_q  <= bus.b;
        op_q <= bus.op_sub;
      end
      if (state_q == StAlign) begin
        big_q   <= big_d;
        small_q <= small_d;
        sign_q  <= sign_d;
        sub_q   <= sa ^ sb;
        zsign_q <= sa & sb;  // exact-zero sign: -0 only when both effective signs are negative
        exp_q   <= exp_d;
      end
      if (state_q == StAdd) sum_q <= sum_d;
      if (state_q == StNorm) begin
        norm_q <= norm_d;
        nexp_q <= nexp_d;
      end
      if (state_q == StRound) begin
        result_q <= res_d;
        inv_q    <= inv_d;
        ovf_q    <= ovf_d;
        unf_q    <= unf_d;
        inx_q    <= inx_d;
        done_q   <= 1'b1;
      end
    end
  end

  assign bus.busy         = (state_q != StIdle);
  assign bus.done         = done_q;
  assign bus.result       = result_q;
  assign bus.flag_invalid = inv_q;
  assign bus.flag_ovf     = ovf_q;
  assign bus.flag_unf     = unf_q;
  assign bus.flag_inexact = inx_q;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed-vector bench for fp_addsub_seq (single precision), plus timing and reset sequences.
module tb_fp_addsub_seq;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  fp_addsub_if #(.EXP_W(8), .MAN_W(23)) bus ();

  fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Flag nibble order: {invalid, ovf, unf, inexact}
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] res;
    logic [3:0]  fl;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  function automatic logic [3:0] flags_now();
    return {bus.flag_invalid, bus.flag_ovf, bus.flag_unf, bus.flag_inexact};
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic op,
                        output logic [31:0] res, output logic [3:0] fl,
                        output int lat, output int busy_cyc);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.a      = a;
    bus.b      = b;
    bus.op_sub = op;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat       = 0;
    busy_cyc  = 0;
    while (!bus.done && lat < 10) begin
      if (bus.busy) busy_cyc++;
      @(posedge clk);
      #1;
      lat++;
    end
    res = bus.result;
    fl  = flags_now();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res;
    logic [3:0]  fl;
    int          lat, bc;
    int          dcount, first_at, second_at, guard;
    logic [31:0] r1, r2;

    bus.start  = 1'b0;
    bus.op_sub = 1'b0;
    bus.a      = '0;
    bus.b      = '0;

    vecs.push_back('{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000});
    vecs.push_back('{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000});
    vecs.push_back('{32'hC0A00000, 32'h40400000, 1'b0, 32'hC0000000, 4'b0000});
    vecs.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101});
    vecs.push_back('{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000});
    vecs.push_back('{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001});
    vecs.push_back('{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001});
    vecs.push_back('{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001});
    vecs.push_back('{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000});
    vecs.push_back('{32'hFFC00001, 32'h00000000, 1'b1, 32'h7FC00000, 4'b1000});
    vecs.push_back('{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000});
    vecs.push_back('{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000});
    vecs.push_back('{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000});
    vecs.push_back('{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000});
    vecs.push_back('{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0000});
    vecs.push_back('{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000});
    vecs.push_back('{32'h40490FDB, 32'h00000000, 1'b0, 32'h40490FDB, 4'b0000});
    vecs.push_back('{32'h00000000, 32'h40490FDB, 1'b1, 32'hC0490FDB, 4'b0000});
    vecs.push_back('{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000});
    vecs.push_back('{32'h00400000, 32'h00400000, 1'b0, 32'h00000000, 4'b0000});
    vecs.push_back('{32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 4'b0011});
    vecs.push_back('{32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 4'b0011});
    vecs.push_back('{32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 4'b0000});
    vecs.push_back('{32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000, 4'b0101});
    vecs.push_back('{32'h3F800000, 32'hBFC00000, 1'b0, 32'hBF000000, 4'b0000});
    vecs.push_back('{32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 4'b0001});
    vecs.push_back('{32'h3F800000, 32'h33800001, 1'b1, 32'h3F7FFFFF, 4'b0001});

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",   32'(bus.busy), 32'd0);
    chk("rst_done",   32'(bus.done), 32'd0);
    chk("rst_result", bus.result, 32'h0);
    chk("rst_flags",  32'(flags_now()), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Timing of a single operation
    run_op(32'h3F800000, 32'h40000000, 1'b0, res, fl, lat, bc);
    chk("t1_latency",   32'(lat), 32'd4);
    chk("t1_busy_cyc",  32'(bc), 32'd4);
    chk("t1_busy_done", 32'(bus.busy), 32'd0);
    chk("t1_result",    res, 32'h40400000);
    chk("t1_flags",     32'(fl), 32'd0);
    @(posedge clk);
    #1;
    chk("t1_done_pulse", 32'(bus.done), 32'd0);
    chk("t1_held",       bus.result, 32'h40400000);

    // Vector table
    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, res, fl, lat, bc);
      chk($sformatf("vec%0d_done", i), 32'(lat), 32'd4);
      chk($sformatf("vec%0d_res", i), res, vecs[i].res);
      chk($sformatf("vec%0d_flags", i), 32'(fl), 32'(vecs[i].fl));
    end

    // start held high: issue interval 5, operands changed mid-flight
    dcount    = 0;
    first_at  = -1;
    second_at = -1;
    r1        = '0;
    r2        = '0;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.a      = 32'h3F800000;
    bus.b      = 32'h40000000;
    bus.op_sub = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        bus.a = 32'h40000000;
        bus.b = 32'h40000000;
      end
      if (bus.done) begin
        dcount++;
        if (dcount == 1) begin
          first_at = i;
          r1       = bus.result;
        end else if (dcount == 2) begin
          second_at = i;
          r2        = bus.result;
        end
      end
    end
    bus.start = 1'b0;
    chk("t5_done_count", 32'(dcount), 32'd2);
    chk("t5_first_at",   32'(first_at), 32'd4);
    chk("t5_spacing",    32'(second_at - first_at), 32'd5);
    chk("t5_first_res",  r1, 32'h40400000);
    chk("t5_second_res", r2, 32'h40800000);
    guard = 0;
    while (bus.busy && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("t5_drain_idle", 32'(bus.busy), 32'd0);

    // Reset in the middle of an operation
    @(negedge clk);
    bus.start  = 1'b1;
    bus.a      = 32'h3F800000;
    bus.b      = 32'h3F800000;
    bus.op_sub = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_busy",   32'(bus.busy), 32'd0);
    chk("t6_done",   32'(bus.done), 32'd0);
    chk("t6_result", bus.result, 32'h0);
    chk("t6_flags",  32'(flags_now()), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) dcount++;
    end
    chk("t6_no_done", 32'(dcount), 32'd0);
    run_op(32'h3F800000, 32'h40000000, 1'b0, res, fl, lat, bc);
    chk("t6_next_lat", 32'(lat), 32'd4);
    chk("t6_next_res", res, 32'h40400000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
